// File: rtl/ser_pkg.sv
// ser_pkg: shared types and helpers for the symbol serializer.
//   ser_state_t  : serializer FSM state (IDLE, SHIFT)
//   STATUS_CNT_W : width of the optional words_sent status counter
//   nsym()       : number of symbols a word of the given width splits into
package ser_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int STATUS_CNT_W = 16;

  // Symbols per word; callers guarantee sym_bits divides width.
  function automatic int nsym(input int width, input int sym_bits);
    return width / sym_bits;
  endfunction

endpackage

// File: rtl/symbol_serializer.sv
// symbol_serializer: parallel-to-serial converter for the modulator front end.
// A WIDTH-bit word taken over a valid/ready handshake is emitted as
// WIDTH/SYM_BITS symbols, one symbol consumed per sym_tick high cycle.
// A one-word holding buffer lets consecutive words stream with no gap.
//
// Ports:
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_data    : parallel word, sampled only on the accept edge
//   in_valid   : in_data valid
//   in_ready   : holding buffer free (driven from registers only)
//   sym_tick   : advance strobe, one symbol per high cycle
//   sym_out    : current symbol (zero when no word is shifting)
//   sym_valid  : sym_out carries word data
//   word_done  : one-cycle pulse after the last symbol of a word is consumed
//   busy       : word shifting or holding buffer occupied
// Optional (macro SER_STATUS_EN):
//   cnt_clr    : synchronous clear of the status registers
//   words_sent : saturating count of completed words
//   underrun   : sticky, tick seen while starved after at least one word
module symbol_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int SYM_BITS  = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sym_tick,
  output logic [SYM_BITS-1:0]     sym_out,
  output logic                    sym_valid,
  output logic                    word_done,
`ifdef SER_STATUS_EN
  input  logic                    cnt_clr,
  output logic [STATUS_CNT_W-1:0] words_sent,
  output logic                    underrun,
`endif
  output logic                    busy
);

  localparam int NSYM   = nsym(WIDTH, SYM_BITS);
  localparam int IDX_W  = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int BASE_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NSYM - 1);

  if ((WIDTH % SYM_BITS) != 0) begin : g_bad_sym_bits
    $error("symbol_serializer: SYM_BITS (%0d) must divide WIDTH (%0d)", SYM_BITS, WIDTH);
  end

  ser_state_t        state_r;
  logic [WIDTH-1:0]  sreg_r;
  logic [WIDTH-1:0]  hbuf_r;
  logic              hvalid_r;
  logic [IDX_W-1:0]  idx_r;
  logic              word_done_r;
  logic              done_s;
  int                sel_s;
  logic [BASE_W-1:0] base_s;

  assign in_ready  = !hvalid_r;
  assign sym_valid = (state_r == SHIFT);
  assign busy      = (state_r != IDLE) || hvalid_r;
  assign word_done = word_done_r;

  // Last-symbol consumption: shared by the FSM and the status counters.
  always_comb begin
    done_s = 1'b0;
    if ((state_r == SHIFT) && sym_tick && (idx_r == IDX_LAST)) begin
      done_s = 1'b1;
    end else begin
      done_s = 1'b0;
    end
  end

  // Symbol select: idx counts consumption order, mapped to a slice per MSB_FIRST.
  always_comb begin
    sel_s   = 0;
    base_s  = '0;
    sym_out = '0;
    if (state_r == SHIFT) begin
      if (MSB_FIRST != 0) begin
        sel_s = NSYM - 1 - int'(idx_r);
      end else begin
        sel_s = int'(idx_r);
      end
      base_s  = BASE_W'(sel_s * SYM_BITS);
      sym_out = sreg_r[base_s +: SYM_BITS];
    end else begin
      sym_out = '0;
    end
  end

  // Serializer FSM with holding buffer, shift register and symbol index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      sreg_r      <= '0;
      hbuf_r      <= '0;
      hvalid_r    <= 1'b0;
      idx_r       <= '0;
      word_done_r <= 1'b0;
    end else begin
      word_done_r <= 1'b0;
      // Accept and reload never coincide: accept needs hvalid low, reload needs it high.
      if (in_valid && !hvalid_r) begin
        hbuf_r   <= in_data;
        hvalid_r <= 1'b1;
      end
      case (state_r)
        IDLE: begin
          if (hvalid_r) begin
            sreg_r   <= hbuf_r;
            hvalid_r <= 1'b0;
            idx_r    <= '0;
            state_r  <= SHIFT;
          end
        end
        SHIFT: begin
          if (done_s) begin
            word_done_r <= 1'b1;
            if (hvalid_r) begin
              // Gapless reload: next word's first symbol shows on the next cycle.
              sreg_r   <= hbuf_r;
              hvalid_r <= 1'b0;
              idx_r    <= '0;
            end else begin
              state_r <= IDLE;
            end
          end else if (sym_tick) begin
            idx_r <= idx_r + 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef SER_STATUS_EN
  // Status registers: clear has priority over a same-cycle increment or set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_sent <= '0;
      underrun   <= 1'b0;
    end else if (cnt_clr) begin
      words_sent <= '0;
      underrun   <= 1'b0;
    end else begin
      if (done_s && (words_sent != {STATUS_CNT_W{1'b1}})) begin
        words_sent <= words_sent + 1'b1;
      end
      if ((state_r == IDLE) && !hvalid_r && sym_tick && (words_sent != '0)) begin
        underrun <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_symbol_serializer.sv
module tb_symbol_serializer;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] in_data;
  logic in_valid, sym_tick;

  logic       s0;
  logic [1:0] s1;
  logic [7:0] s2;
  logic rdy0, rdy1, rdy2, v0, v1, v2, d0, d1, d2, b0, b1, b2;

`ifdef SER_STATUS_EN
  logic cnt_clr = 1'b0;
  logic [15:0] ws0, ws1, ws2;
  logic ur0, ur1, ur2;
`endif

  always #5 clk = ~clk;

  // dut0: BPSK LSB first, dut1: QPSK MSB first, dut2: one symbol per word
  symbol_serializer #(.WIDTH(16), .SYM_BITS(1), .MSB_FIRST(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy0),
    .sym_tick(sym_tick), .sym_out(s0), .sym_valid(v0), .word_done(d0),
`ifdef SER_STATUS_EN
    .cnt_clr(cnt_clr), .words_sent(ws0), .underrun(ur0),
`endif
    .busy(b0));

  symbol_serializer #(.WIDTH(16), .SYM_BITS(2), .MSB_FIRST(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
    .sym_tick(sym_tick), .sym_out(s1), .sym_valid(v1), .word_done(d1),
`ifdef SER_STATUS_EN
    .cnt_clr(cnt_clr), .words_sent(ws1), .underrun(ur1),
`endif
    .busy(b1));

  symbol_serializer #(.WIDTH(8), .SYM_BITS(8), .MSB_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data[7:0]), .in_valid(in_valid), .in_ready(rdy2),
    .sym_tick(sym_tick), .sym_out(s2), .sym_valid(v2), .word_done(d2),
`ifdef SER_STATUS_EN
    .cnt_clr(cnt_clr), .words_sent(ws2), .underrun(ur2),
`endif
    .busy(b2));

  logic [7:0] so [3];
  logic sv [3], wd [3], rdy [3], bz [3];
  assign so[0] = {7'b0, s0};
  assign so[1] = {6'b0, s1};
  assign so[2] = s2;
  assign sv[0] = v0;   assign sv[1] = v1;   assign sv[2] = v2;
  assign wd[0] = d0;   assign wd[1] = d1;   assign wd[2] = d2;
  assign rdy[0] = rdy0; assign rdy[1] = rdy1; assign rdy[2] = rdy2;
  assign bz[0] = b0;   assign bz[1] = b1;   assign bz[2] = b2;

  int errors = 0;
  int checks = 0;

  // Reference model: expected symbol stream per DUT
  int qsym [3][0:1023];
  bit qlast [3][0:1023];
  int qh [3], qt [3], npush [3];
  bit dexp [3];
  int obs [3][0:255];
  int ncons [3], ndone [3];
  logic [15:0] wlist [0:15];
  int wcount;

  function automatic int pw(input int d);
    case (d)
      0: return 16;
      1: return 16;
      default: return 8;
    endcase
  endfunction

  function automatic int ps(input int d);
    case (d)
      0: return 1;
      1: return 2;
      default: return 8;
    endcase
  endfunction

  function automatic int pm(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  // Split an accepted word into its symbols in transmission order.
  function automatic void push(input int d, input logic [15:0] w);
    int n, mask, wv, sh;
    n    = pw(d) / ps(d);
    mask = (1 << ps(d)) - 1;
    wv   = int'(w) & ((1 << pw(d)) - 1);
    for (int k = 0; k < n; k++) begin
      sh = (pm(d) != 0) ? (n - 1 - k) * ps(d) : k * ps(d);
      qsym[d][qt[d] % 1024]  = (wv >> sh) & mask;
      qlast[d][qt[d] % 1024] = (k == n - 1);
      qt[d]++;
    end
    npush[d]++;
  endfunction

  task automatic do_reset();
    in_valid = 1'b0;
    sym_tick = 1'b0;
    in_data  = 16'h0000;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // mode 0: random, mode 1: tick every cycle, mode 2: tick every 4th cycle.
  // fd selects the DUT whose readiness paces wlist in directed modes.
  task automatic run_stream(input int mode, input int fd, input int ncyc, input bit gapchk);
    int widx;
    bit seen, feeding;
    logic [7:0] expv;
    for (int d = 0; d < 3; d++) begin
      qh[d] = 0; qt[d] = 0; npush[d] = 0; dexp[d] = 1'b0; ncons[d] = 0; ndone[d] = 0;
    end
    widx = 0;
    seen = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (wd[d] !== dexp[d]) begin
          errors++;
          $display("FAIL word_done dut%0d cyc %0d: got %0b expected %0b", d, c, wd[d], dexp[d]);
        end
        if (wd[d] === 1'b1) ndone[d]++;
      end
      if (mode == 0) begin
        feeding  = (c < ncyc - 200);
        in_valid = feeding && ($urandom_range(0, 1) == 1);
        in_data  = 16'($urandom);
        sym_tick = feeding ? ($urandom_range(0, 2) != 0) : 1'b1;
      end else begin
        feeding  = (widx < wcount);
        in_valid = feeding;
        in_data  = feeding ? wlist[widx] : 16'h0000;
        sym_tick = (mode == 1) ? 1'b1 : ((c % 4) == 3);
      end
      for (int d = 0; d < 3; d++) begin
        if (in_valid && rdy[d]) push(d, in_data);
        dexp[d] = 1'b0;
        if (sym_tick && sv[d]) begin
          checks++;
          if (qh[d] == qt[d]) begin
            errors++;
            $display("FAIL sym_extra dut%0d cyc %0d: got symbol %0d expected none", d, c, so[d]);
          end else begin
            expv = 8'(qsym[d][qh[d] % 1024]);
            if (so[d] !== expv) begin
              errors++;
              $display("FAIL sym_out dut%0d sym %0d: got %0d expected %0d", d, ncons[d], so[d], expv);
            end
            dexp[d] = qlast[d][qh[d] % 1024];
            qh[d]++;
          end
          if (ncons[d] < 256) obs[d][ncons[d]] = int'(so[d]);
          ncons[d]++;
        end
      end
      if (in_valid && rdy[fd]) widx++;
      if (gapchk) begin
        if (sv[fd]) seen = 1'b1;
        else if (seen && (qh[fd] != qt[fd])) begin
          checks++;
          errors++;
          $display("FAIL gap dut%0d cyc %0d: got sym_valid 0 expected 1", fd, c);
        end
      end
    end
    in_valid = 1'b0;
    sym_tick = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (wd[d] !== dexp[d]) begin
        errors++;
        $display("FAIL word_done_tail dut%0d: got %0b expected %0b", d, wd[d], dexp[d]);
      end
      if (wd[d] === 1'b1) ndone[d]++;
    end
    if (mode != 0) begin
      checks++;
      if (widx < wcount) begin
        errors++;
        $display("FAIL feed_timeout dut%0d: got %0d words accepted expected %0d", fd, widx, wcount);
      end
    end
    for (int d = 0; d < 3; d++) begin
      if (mode == 0 || d == fd) begin
        checks++;
        if (qh[d] != qt[d] || ndone[d] != npush[d]) begin
          errors++;
          $display("FAIL drain dut%0d: got %0d left, %0d done expected 0 left, %0d done",
                   d, qt[d] - qh[d], ndone[d], npush[d]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; sym_tick = 1'b0; in_data = 16'h0000;
    #12;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (rdy[d] !== 1'b1 || sv[d] !== 1'b0 || so[d] !== 8'h00 || wd[d] !== 1'b0 || bz[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: got rdy=%b sv=%b so=%0d wd=%b busy=%b expected 1 0 0 0 0",
                 d, rdy[d], sv[d], so[d], wd[d], bz[d]);
      end
    end
    do_reset();
  endtask

  task automatic test_idle_ticks();
    do_reset();
    sym_tick = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (sv[d] !== 1'b0 || bz[d] !== 1'b0 || rdy[d] !== 1'b1 || wd[d] !== 1'b0) begin
          errors++;
          $display("FAIL idle_tick dut%0d: got sv=%b busy=%b rdy=%b wd=%b expected 0 0 1 0",
                   d, sv[d], bz[d], rdy[d], wd[d]);
        end
      end
    end
    sym_tick = 1'b0;
  endtask

  task automatic test_bpsk_lsb();
    int exp_a [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    do_reset();
    wlist[0] = 16'hA5C3; wcount = 1;
    run_stream(1, 0, 40, 1'b0);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[0][k] != exp_a[k]) begin
        errors++;
        $display("FAIL a5c3_sym%0d: got %0d expected %0d", k, obs[0][k], exp_a[k]);
      end
    end
    checks++;
    if (ndone[0] != 1 || ncons[0] != 16 || sv[0] !== 1'b0) begin
      errors++;
      $display("FAIL a5c3_end: got done=%0d syms=%0d sv=%b expected 1 16 0", ndone[0], ncons[0], sv[0]);
    end
  endtask

  task automatic test_qpsk_back_to_back();
    int exp_b [8] = '{0,1,2,3,1,0,3,2};
    do_reset();
    wlist[0] = 16'h1B4E; wlist[1] = 16'hFFFF; wcount = 2;
    run_stream(1, 1, 40, 1'b1);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (obs[1][k] != ((k < 8) ? exp_b[k] : 3)) begin
        errors++;
        $display("FAIL qpsk_sym%0d: got %0d expected %0d", k, obs[1][k], (k < 8) ? exp_b[k] : 3);
      end
    end
    checks++;
    if (ndone[1] != 2) begin
      errors++;
      $display("FAIL qpsk_done: got %0d expected 2", ndone[1]);
    end
  endtask

  task automatic test_sparse_ticks();
    do_reset();
    wlist[0] = 16'h0001; wlist[1] = 16'h0002; wlist[2] = 16'h0003; wcount = 3;
    run_stream(2, 0, 400, 1'b1);
    checks++;
    if (ncons[0] != 48 || ndone[0] != 3) begin
      errors++;
      $display("FAIL sparse: got syms=%0d done=%0d expected 48 3", ncons[0], ndone[0]);
    end
  endtask

  task automatic test_reset_midword();
    int cnt, guard;
    do_reset();
    in_data = 16'hFFFF; in_valid = 1'b1; sym_tick = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cnt = 0; guard = 0;
    while (cnt < 7 && guard < 40) begin
      if (v0) cnt++;
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cnt < 7 || v0 !== 1'b1 || s0 !== 1'b1) begin
      errors++;
      $display("FAIL midword_reach: got cnt=%0d sv=%b so=%b expected 7 1 1", cnt, v0, s0);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (v0 !== 1'b0 || s0 !== 1'b0 || rdy0 !== 1'b1 || b0 !== 1'b0 || d0 !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: got sv=%b so=%b rdy=%b busy=%b wd=%b expected 0 0 1 0 0", v0, s0, rdy0, b0, d0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sym_tick = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (d0 !== 1'b0 || v0 !== 1'b0) begin
        errors++;
        $display("FAIL post_reset: got wd=%b sv=%b expected 0 0", d0, v0);
      end
    end
    wlist[0] = 16'h8002; wcount = 1;
    run_stream(1, 0, 40, 1'b0);
    checks++;
    if (obs[0][0] != 0 || obs[0][1] != 1 || obs[0][15] != 1 || ncons[0] != 16) begin
      errors++;
      $display("FAIL restart: got s0=%0d s1=%0d s15=%0d n=%0d expected 0 1 1 16",
               obs[0][0], obs[0][1], obs[0][15], ncons[0]);
    end
  endtask

  task automatic test_nsym1();
    do_reset();
    wlist[0] = 16'h003C; wcount = 1;
    run_stream(1, 2, 20, 1'b0);
    checks++;
    if (obs[2][0] != 32'h3C || ncons[2] != 1 || ndone[2] != 1) begin
      errors++;
      $display("FAIL nsym1: got sym=%0h n=%0d done=%0d expected 3c 1 1", obs[2][0], ncons[2], ndone[2]);
    end
  endtask

  task automatic test_random();
    do_reset();
    wcount = 0;
    run_stream(0, 0, 1500, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_ticks();
    test_bpsk_lsb();
    test_qpsk_back_to_back();
    test_sparse_ticks();
    test_reset_midword();
    test_nsym1();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
